// File: rtl/ahb_mgr_input_stage_if.sv
// AHB-Lite address/data bundle, used for both the manager port and
// the replayed shared-bus side of the input stage.
interface ahb_mgr_input_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            HTRANS;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport master (
        output HTRANS, HADDR, HWRITE, HSIZE,
        output HBURST, HPROT, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HTRANS, HADDR, HWRITE, HSIZE,
        input  HBURST, HPROT, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_mgr_input_stage.sv
// Per-manager AHB input stage: registers one address phase, requests
// the shared bus, replays it as a single NONSEQ and stalls the manager.
module ahb_mgr_input_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    ahb_mgr_input_stage_if.slave         mgr,
    ahb_mgr_input_stage_if.master        bus,
    output logic                         req,
    input  logic                         grant
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
    } state_t;

    // Bursts are replayed as INCR singles, so the burst type is not held.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [3:0]            prot;
    } hold_t;

    state_t state;
    state_t state_nxt;
    hold_t  held;
    logic   capture;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= S_IDLE;
            held  <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                held <= '{
                    addr:  mgr.HADDR,
                    write: mgr.HWRITE,
                    size:  mgr.HSIZE,
                    prot:  mgr.HPROT
                };
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req         = 1'b0;
        mgr.HREADY  = 1'b1;
        mgr.HRESP   = 1'b0;
        mgr.HRDATA  = '0;
        bus.HTRANS  = 2'b00;
        bus.HADDR   = '0;
        bus.HWRITE  = 1'b0;
        bus.HSIZE   = 3'b000;
        bus.HBURST  = 3'b000;
        bus.HPROT   = 4'h0;
        bus.HWDATA  = '0;
        capture     = 1'b0;

        unique case (state)
            S_IDLE: begin
                state_nxt = S_IDLE;
            end
            S_WAIT: begin
                req        = 1'b1;
                mgr.HREADY = 1'b0;
                if (grant) begin
                    bus.HTRANS = 2'b10;
                    bus.HADDR  = held.addr;
                    bus.HWRITE = held.write;
                    bus.HSIZE  = held.size;
                    bus.HBURST = 3'b001;
                    bus.HPROT  = held.prot;
                    if (bus.HREADY) state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                mgr.HREADY = bus.HREADY;
                mgr.HRESP  = bus.HRESP;
                mgr.HRDATA = bus.HRDATA;
                bus.HWDATA = mgr.HWDATA;
                if (bus.HREADY) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A new NONSEQ/SEQ is taken whenever the manager sees HREADY high.
        capture = mgr.HREADY && mgr.HTRANS[1];
        if (capture) state_nxt = S_WAIT;
    end
endmodule

// File: tb/tb_ahb_mgr_input_stage.sv
// Scoreboard bench for ahb_mgr_input_stage: manager/bus/arbiter models,
// expected replays queued at capture and checked by a negedge monitor.
module tb_ahb_mgr_input_stage;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [1:0]  tr;
        logic [31:0] a;
        logic        w;
        logic [2:0]  sz;
        logic [2:0]  bu;
        logic [3:0]  pr;
        logic [31:0] wd;
    } xfer_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic grant = 1'b1;
    logic req;

    ahb_mgr_input_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m ();
    ahb_mgr_input_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b ();

    ahb_mgr_input_stage #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .mgr    (m.slave),
        .bus    (b.master),
        .req    (req),
        .grant  (grant)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    xfer_t mq[$];
    xfer_t aq[$];
    xfer_t cur;
    logic  pending = 1'b0;
    logic  in_dp   = 1'b0;
    logic  mon_en  = 1'b0;
    logic [31:0] cur_wd = '0;
    logic [31:0] rd_val = '0;
    int dp_n = 0, dp_w = 0, pw = 0;
    int stall = 0, gdelay = 0, dpw = 0;
    bit dp_err = 1'b0, err_next = 1'b0, rnd = 1'b0;

    int waits = 0, reqs = 0, done_cnt = 0, cyc = 0;
    int last_waits = 0, last_reqs = 0;
    int dcyc[$];
    logic last_resp = 1'b0;
    logic [31:0] last_rdata = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(logic [1:0] tr, logic [31:0] a,
                                 logic w, logic [2:0] bu,
                                 logic [31:0] wd);
        xfer_t x;
        x.tr = tr; x.a = a; x.w = w; x.sz = 3'd2;
        x.bu = bu; x.pr = 4'h3; x.wd = wd;
        return x;
    endfunction

    function automatic logic [44:0] bus_addr_bits();
        return {b.HTRANS, b.HADDR, b.HWRITE, b.HSIZE, b.HBURST, b.HPROT};
    endfunction

    task automatic drive_mgr();
        m.HTRANS = cur.tr; m.HADDR = cur.a; m.HWRITE = cur.w;
        m.HSIZE  = cur.sz; m.HBURST = cur.bu; m.HPROT = cur.pr;
        m.HWDATA = cur_wd;
    endtask

    // Monitor: per-cycle expectations from the transaction model.
    always @(negedge clk) begin
        cyc++;
        if (mon_en && !rst) begin
            chk("req", req, pending);
            if (pending && grant) begin
                chk("bus_htrans", b.HTRANS, 2'b10);
                chk("bus_haddr", b.HADDR, aq[0].a);
                chk("bus_hwrite", b.HWRITE, aq[0].w);
                chk("bus_hsize", b.HSIZE, aq[0].sz);
                chk("bus_hburst", b.HBURST, 3'b001);
                chk("bus_hprot", b.HPROT, aq[0].pr);
            end else begin
                chk("bus_addr_idle", bus_addr_bits(), 64'd0);
            end
            if (in_dp) begin
                chk("bus_hwdata", b.HWDATA, cur_wd);
                chk("mgr_passthru", {m.HREADY, m.HRESP, m.HRDATA},
                    {b.HREADY, b.HRESP, b.HRDATA});
            end else begin
                chk("data_quiet", {b.HWDATA, m.HRDATA}, 64'd0);
                chk("mgr_rsp", {m.HREADY, m.HRESP}, {!pending, 1'b0});
            end
            if ((pending || in_dp) && !m.HREADY) waits++;
            if (req) reqs++;
            if (pending && grant && b.HREADY) aq.delete(0);
            if (in_dp && b.HREADY) begin
                last_waits = waits; last_reqs = reqs;
                waits = 0; reqs = 0;
                last_resp  = m.HRESP;
                last_rdata = m.HRDATA;
                dcyc.push_back(cyc);
                done_cnt++;
            end
        end
    end

    // One clock of manager, arbiter and shared-bus behaviour.
    task automatic step();
        logic acc, cap, bacc, ddone, ghr;
        @(negedge clk);
        acc   = in_dp ? b.HREADY : !pending;
        cap   = acc && cur.tr[1];
        bacc  = pending && grant && b.HREADY;
        ddone = in_dp && b.HREADY;
        ghr   = b.HREADY;
        @(posedge clk);
        if (ddone) in_dp = 1'b0;
        if (bacc) begin
            pending = 1'b0; in_dp = 1'b1; dp_n = 0;
            dp_err = rnd ? ($urandom_range(0, 5) == 0) : err_next;
            dp_w   = rnd ? int'($urandom_range(0, 2)) : dpw;
            err_next = 1'b0;
        end
        if (cap) begin
            aq.push_back(cur);
            pending = 1'b1; pw = 0; cur_wd = cur.wd;
        end
        if (acc) cur = (mq.size() > 0) ? mq.pop_front()
                                      : mk(2'b00, 32'h0, 1'b0, 3'b0, 32'h0);
        #1;
        drive_mgr();
        if (ghr) grant = rnd ? ($urandom_range(0, 2) != 0)
                             : (!pending || pw >= gdelay);
        if (pending) pw++;
        if (in_dp) begin
            if (dp_err) begin
                b.HREADY = (dp_n == dp_w + 1);
                b.HRESP  = (dp_n >= dp_w);
            end else begin
                b.HREADY = (dp_n >= dp_w);
                b.HRESP  = 1'b0;
            end
            dp_n++;
        end else if (rnd) begin
            b.HREADY = ($urandom_range(0, 3) != 0);
            b.HRESP  = ($urandom_range(0, 7) == 0);
        end else begin
            b.HREADY = !(pending && stall > 0);
            b.HRESP  = 1'b0;
            if (pending && stall > 0) stall--;
        end
        b.HRDATA = rnd ? $urandom : rd_val;
    endtask

    task automatic run_done(int n, int budget, string name);
        int start = done_cnt;
        for (int i = 0; i < budget && done_cnt < start + n; i++) step();
        chk(name, done_cnt - start, n);
    endtask

    task automatic reset_model();
        pending = 1'b0; in_dp = 1'b0;
        aq.delete(); mq.delete();
        cur = mk(2'b00, 32'h0, 1'b0, 3'b0, 32'h0);
        cur_wd = '0; waits = 0; reqs = 0;
        stall = 0; err_next = 1'b0; gdelay = 0; dpw = 0;
        grant = 1'b1; b.HREADY = 1'b1; b.HRESP = 1'b0;
        drive_mgr();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_ctl"}, {req, m.HREADY, m.HRESP}, 3'b010);
        chk({tag, "_bus"}, bus_addr_bits(), 64'd0);
        chk({tag, "_data"}, {b.HWDATA, m.HRDATA}, 64'd0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        reset_model();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int nx, start, r;
        xfer_t x;
        cur = mk(2'b00, 32'h0, 1'b0, 3'b0, 32'h0);
        drive_mgr();
        b.HREADY = 1'b1; b.HRESP = 1'b0; b.HRDATA = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst_init");
        rst = 1'b0; mon_en = 1'b1;

        // Single write, minimum latency: one wait state.
        mq.push_back(mk(2'b10, 32'h0000_1000, 1'b1, 3'b000, 32'hDEAD_BEEF));
        run_done(1, 20, "single_done");
        chk("single_waits", last_waits, 1);

        // Grant held off for three cycles after capture.
        gdelay = 3; rd_val = 32'h1234_5678;
        mq.push_back(mk(2'b10, 32'h0000_2000, 1'b0, 3'b000, 32'h0));
        run_done(1, 30, "gdelay_done");
        chk("gdelay_waits", last_waits, 4);
        chk("gdelay_reqs", last_reqs, 4);
        chk("gdelay_rdata", last_rdata, 32'h1234_5678);
        gdelay = 0;

        // INCR4 burst replayed back-to-back as singles.
        mq.push_back(mk(2'b10, 32'h00, 1'b1, 3'b011, 32'hA0));
        mq.push_back(mk(2'b11, 32'h04, 1'b1, 3'b011, 32'hA1));
        mq.push_back(mk(2'b11, 32'h08, 1'b1, 3'b011, 32'hA2));
        mq.push_back(mk(2'b11, 32'h0C, 1'b1, 3'b011, 32'hA3));
        run_done(4, 40, "burst_done");
        chk("burst_span", dcyc[dcyc.size()-1] - dcyc[dcyc.size()-4], 6);

        // Two-cycle ERROR response.
        err_next = 1'b1;
        mq.push_back(mk(2'b10, 32'h0000_3000, 1'b1, 3'b000, 32'h55));
        run_done(1, 20, "err_done");
        chk("err_resp", last_resp, 1'b1);
        chk("err_waits", last_waits, 2);
        #1 chk("err_idle", {m.HREADY, req}, 2'b10);

        // Shared bus stalls the granted address phase for two cycles.
        stall = 2;
        mq.push_back(mk(2'b10, 32'h0000_4000, 1'b0, 3'b000, 32'h0));
        run_done(1, 20, "stall_done");
        chk("stall_waits", last_waits, 3);

        // Reset while waiting for grant.
        gdelay = 5;
        mq.push_back(mk(2'b10, 32'h0000_5000, 1'b1, 3'b000, 32'h66));
        for (int i = 0; i < 10 && !pending; i++) step();
        chk("reach_wait", pending, 1'b1);
        pulse_reset();

        // Reset in the middle of a stalled data phase.
        dpw = 3;
        mq.push_back(mk(2'b10, 32'h0000_6000, 1'b0, 3'b000, 32'h0));
        for (int i = 0; i < 10 && !in_dp; i++) step();
        chk("reach_data", in_dp, 1'b1);
        pulse_reset();

        // BUSY after reset must not be captured.
        start = done_cnt;
        mq.push_back(mk(2'b01, 32'h0000_7000, 1'b1, 3'b000, 32'h0));
        mq.push_back(mk(2'b01, 32'h0000_7004, 1'b1, 3'b000, 32'h0));
        repeat (6) step();
        chk("busy_reqs", reqs, 0);
        chk("busy_done", done_cnt - start, 0);

        // Randomised traffic against the transaction model.
        rnd = 1'b1; nx = 0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            x = mk(2'b00, $urandom & 32'hFFFF_FFFC, 1'($urandom),
                   3'($urandom), $urandom);
            x.sz = 3'($urandom); x.pr = 4'($urandom);
            x.tr = (r < 4) ? 2'b00 : (r < 5) ? 2'b01 :
                   (r < 8) ? 2'b10 : 2'b11;
            if (x.tr[1]) nx++;
            mq.push_back(x);
        end
        run_done(nx, 20000, "random_done");
        rnd = 1'b0;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
